// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and scan-state type for the seven-segment scanner.
package seg_pkg;
    localparam int NIB_W = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic AN_OFF = 1'b1;
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_e;
endpackage

// File: rtl/seven_segment.sv
// seven_segment: hex nibble to active-low segments, bit order {g,f,e,d,c,b,a}.
module seven_segment (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            default: seg_o = 7'h0E;
        endcase
    end
endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: round-robin multiplexed display with dead-time blanking and frame-synchronous commit.
// Optional decimal points when SEG_SCAN_DP_EN is defined.
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1,
    localparam int CW = $clog2(PRESCALE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NIB_W*DIGITS-1:0] value,
    input  logic                    load,
    output logic                    pending,
    input  logic                    lzb_en,
    output logic [6:0]              seg,
    output logic [DIGITS-1:0]       an,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_tick
`ifdef SEG_SCAN_DP_EN
    ,
    input  logic [DIGITS-1:0]       dp_in,
    output logic                    dp
`endif
);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    scan_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NIB_W*DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
    logic pending_q, pending_d, ft_q, ft_d, wrap, commit, lit;
    logic [6:0] seg_q, seg_d, dec;
    logic [DIGITS-1:0] an_q, an_d;

    always_comb begin
        wrap = state_q != IDLE && cnt_q == CNT_LAST && idx_q == IDX_LAST;
        commit = pending_q && (state_q == IDLE || wrap);
        active_d = commit ? shadow_q : active_q;
        shadow_d = load ? value : shadow_q;
        pending_d = load || (pending_q && !commit);
        cnt_d = (!enable || state_q == IDLE || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d = (!enable || state_q == IDLE) ? '0 : cnt_q != CNT_LAST ? idx_q :
                idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
        state_d = !enable ? IDLE : cnt_d < CNT_SHOW ? BLANK : SHOW;
        ft_d = enable && wrap;
    end

    seven_segment u_dec (
        .hex_i(active_d[{idx_d, 2'b00} +: NIB_W]),
        .seg_o(dec)
    );

    // Digit stays dark when it and every more-significant nibble are zero.
    always_comb begin
        lit = state_d == SHOW && !(lzb_en && idx_d != '0 && (active_d >> {idx_d, 2'b00}) == '0);
        an_d = lit ? ~(DIGITS'(1) << idx_d) : {DIGITS{AN_OFF}};
        seg_d = lit ? dec : SEG_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            ft_q      <= 1'b0;
            seg_q     <= SEG_BLANK;
            an_q      <= {DIGITS{AN_OFF}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ft_q      <= ft_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [DIGITS-1:0] dp_shadow_q, dp_shadow_d, dp_active_q, dp_active_d;
    logic dp_q, dp_d;

    always_comb begin
        dp_shadow_d = load ? dp_in : dp_shadow_q;
        dp_active_d = commit ? dp_shadow_q : dp_active_q;
        dp_d = lit ? ~dp_active_d[idx_d] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_shadow_q <= '0;
            dp_active_q <= '0;
            dp_q        <= 1'b1;
        end else begin
            dp_shadow_q <= dp_shadow_d;
            dp_active_q <= dp_active_d;
            dp_q        <= dp_d;
        end
    end

    assign dp = dp_q;
`endif

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_tick = ft_q;
    assign pending    = pending_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: scoreboard bench using a frame-position reference model.
module tb_seven_segment_scanner;
    localparam int DIGITS = 4, PRESCALE = 8, BLANK_CYCLES = 2;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, load = 1'b0, lzb_en = 1'b0;
    logic [15:0] value = '0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] digit_idx;
    logic frame_tick, pending;
`ifdef SEG_SCAN_DP_EN
    logic [3:0] dp_in = '0;
    logic dp;
`endif

    seven_segment_scanner #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk(clk), .rst(rst), .enable(enable), .value(value), .load(load), .pending(pending),
        .lzb_en(lzb_en), .seg(seg), .an(an), .digit_idx(digit_idx), .frame_tick(frame_tick)
`ifdef SEG_SCAN_DP_EN
        , .dp_in(dp_in), .dp(dp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic [1:0] idx;
        logic       ft;
        logic       pend;
    } obs_t;

    obs_t sb[$];
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    bit run = 0, m_pend = 0;
    int p = 0;
    logic [15:0] m_act = '0, m_sh = '0;
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s pos=%0d got %h expected %h", tag, p, got, exp);
        end
    endtask

    // Frame position p = digit*8 + slot count; model advances then expectation is queued.
    task automatic cyc();
        obs_t e, o;
        bit commit, lit;
        int d;
        commit = m_pend && (!run || p == 31);
        e.ft = run && enable && p == 31;
        if (commit) m_act = m_sh;
        if (load) begin m_sh = value; m_pend = 1; end
        else if (commit) m_pend = 0;
        if (!enable) begin run = 0; p = 0; end
        else if (!run) begin run = 1; p = 0; end
        else p = (p + 1) % 32;
        d = p / 8;
        lit = run && p % 8 >= 2 && !(lzb_en && d != 0 && (m_act >> (4 * d)) == 0);
        e.idx = 2'(d);
        e.pend = m_pend;
        e.an = lit ? ~(4'b1 << d) : 4'hF;
        e.seg = lit ? tbl[m_act[4 * d +: 4]] : 7'h7F;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("cycle", 32'({seg, an, digit_idx, frame_tick, pending}), 32'(o));
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 100 && !(run && p == target); n++) cyc();
        check("run_to", run ? p : -1, 32'(target));
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_idx"}, 32'(digit_idx), 32'h0);
        check({tag, "_ft"}, 32'(frame_tick), 32'h0);
        check({tag, "_pend"}, 32'(pending), 32'h0);
    endtask

    task automatic check_show(input string tag, input logic [3:0] a, input logic [6:0] s);
        check({tag, "_an"}, 32'(an), 32'(a));
        check({tag, "_seg"}, 32'(seg), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_dark("reset");
        @(negedge clk);
        rst = 1'b0;

        do_load(16'h1234);
        check("pend_set", 32'(pending), 32'h1);
        enable = 1'b1;
        cyc();
        check("blank0_an", 32'(an), 32'hF);
        check("no_ft_start", 32'(frame_tick), 32'h0);
        cyc();
        check("blank1_an", 32'(an), 32'hF);
        cyc();
        check_show("d0_first", 4'b1110, 7'b0011001);
        run_to(7);
        check_show("d0_last", 4'b1110, 7'b0011001);
        for (n = 0; n < 64 && !frame_tick; n++) cyc();
        n = 0;
        do begin cyc(); n++; end while (!frame_tick && n < 64);
        check("ft_period", 32'(n), 32'd32);
        check("ft_idx", 32'(digit_idx), 32'h0);

        run_to(18);
        do_load(16'hABCD);
        check("pend_mid", 32'(pending), 32'h1);
        run_to(20);
        check_show("old_d2", 4'b1011, 7'h24);
        run_to(28);
        check_show("old_d3", 4'b0111, 7'h79);
        check("pend_late", 32'(pending), 32'h1);
        run_to(0);
        check("pend_clr", 32'(pending), 32'h0);
        check("ft_commit", 32'(frame_tick), 32'h1);
        run_to(2);  check_show("new_d0", 4'b1110, 7'h21);
        run_to(10); check_show("new_d1", 4'b1101, 7'h46);
        run_to(18); check_show("new_d2", 4'b1011, 7'h03);
        run_to(26); check_show("new_d3", 4'b0111, 7'h08);

        lzb_en = 1'b1;
        do_load(16'h00A0);
        run_to(0);
        run_to(2);  check_show("lzb_d0", 4'b1110, 7'b1000000);
        run_to(10); check_show("lzb_d1", 4'b1101, 7'b0001000);
        run_to(18); check_show("lzb_d2", 4'hF, 7'h7F);
        run_to(26); check_show("lzb_d3", 4'hF, 7'h7F);
        lzb_en = 1'b0;

        do_load(16'h1234);
        run_to(0);
        run_to(19);
        enable = 1'b0;
        cyc();
        check("dis_an", 32'(an), 32'hF);
        check("dis_idx", 32'(digit_idx), 32'h0);
        cyc();
        cyc();
        enable = 1'b1;
        cyc();
        check("reen_an", 32'(an), 32'hF);
        check("reen_ft", 32'(frame_tick), 32'h0);
        cyc();
        check("reen_an1", 32'(an), 32'hF);
        cyc();
        check_show("reen_show", 4'b1110, 7'h19);

`ifdef SEG_SCAN_DP_EN
        dp_in = 4'b0100;
        do_load(16'h1234);
        run_to(0);
        for (int i = 0; i < 32; i++) begin
            cyc();
            check("dp", 32'(dp), (p / 8 == 2 && p % 8 >= 2) ? 32'h0 : 32'h1);
        end
`endif

        run_to(20);
        #2 rst = 1'b1;
        #1;
        check_dark("rst_mid");
        run = 0; p = 0; m_act = '0; m_sh = '0; m_pend = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) cyc();
        check_show("post_rst", 4'b1110, 7'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
